// File: rtl/mdr_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
//   Shared definitions for the memory-data-register load path.
//   - state_e          : load controller FSM states
//   - LS_* codes       : load-size encodings carried on LScontroler/ls_ctrl_out
//   - CNT_W            : width of the read-latency counter (READ_LATENCY <= 7)
//   - is_legal_aligned : size legality and address alignment check
// -----------------------------------------------------------------------------
package mdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] LS_WORD    = 2'b00;
  localparam logic [1:0] LS_HALF    = 2'b01;
  localparam logic [1:0] LS_BYTE    = 2'b10;
  localparam logic [1:0] LS_ILLEGAL = 2'b11;

  localparam int CNT_W = 3;

  // True when the size code is legal and the low address bits suit it:
  // words need a 4-byte boundary, halves a 2-byte boundary, bytes any address.
  function automatic logic is_legal_aligned(input logic [1:0] ls,
                                            input logic [1:0] addr_lo);
    logic ok;
    case (ls)
      LS_WORD: ok = (addr_lo == 2'b00);
      LS_HALF: ok = (addr_lo[0] == 1'b0);
      LS_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mdr_load_ctrl.sv
// -----------------------------------------------------------------------------
// mdr_load_ctrl
//   Issues a single word-aligned memory read for each accepted load request
//   and captures the returned word into the memory data register (MDR).
//
//   Parameter
//     READ_LATENCY : cycles from the mem_re cycle to valid mem_rdata (1..7)
//   Ports
//     clk, reset_n : clock and synchronous active-low reset
//     rd_req       : load request, only looked at while idle
//     addr         : byte address of the load
//     LScontroler  : load size (00 word, 01 half, 10 byte, 11 illegal)
//     mem_re       : memory read enable, high only in ISSUE
//     mem_addr     : word-aligned memory address, held between accesses
//     mem_rdata    : memory read data
//     MDR_out      : captured memory word
//     ls_ctrl_out  : load size paired with MDR_out
//     busy         : high while in ISSUE or WAIT
//     done         : one-cycle pulse when MDR_out holds new data
//     misaligned   : one-cycle pulse when a request is rejected
// -----------------------------------------------------------------------------
module mdr_load_ctrl
  import mdr_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [31:0] addr,
  input  logic [1:0]  LScontroler,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MDR_out,
  output logic [1:0]  ls_ctrl_out,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [1:0]         ls_lat_q, ls_lat_d;       // size of the in-flight access
  logic [1:0]         ls_ctrl_out_q, ls_ctrl_out_d;
  logic [31:0]        mdr_q, mdr_d;
  logic               misaligned_q, misaligned_d;

  // NOTE: every variable gets its default before the case statement, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    ls_lat_d      = ls_lat_q;
    ls_ctrl_out_d = ls_ctrl_out_q;
    mdr_d         = mdr_q;
    misaligned_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          if (is_legal_aligned(LScontroler, addr[1:0])) begin
            // The aligned address is latched now so it is already stable
            // in the ISSUE cycle and simply holds afterwards.
            mem_addr_d = {addr[31:2], 2'b00};
            ls_lat_d   = LScontroler;
            state_d    = ST_ISSUE;
          end else begin
            // Rejected: no access, MDR_out and ls_ctrl_out untouched.
            misaligned_d = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_W'(READ_LATENCY);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // cnt_q == 1 marks the cycle in which mem_rdata is valid; the <=
        // guard keeps the FSM from sticking if the counter were ever 0.
        if (cnt_q <= CNT_W'(1)) begin
          mdr_d         = mem_rdata;
          ls_ctrl_out_d = ls_lat_q;
          state_d       = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop. Reset is synchronous and
  // clears all state, overriding any transition in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      ls_lat_q      <= LS_WORD;
      ls_ctrl_out_q <= LS_WORD;
      mdr_q         <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      ls_lat_q      <= ls_lat_d;
      ls_ctrl_out_q <= ls_ctrl_out_d;
      mdr_q         <= mdr_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // Status outputs decode directly from the state register, which makes
  // busy/done mutually exclusive by construction; misaligned only fires in
  // IDLE, where neither of the others can be high.
  assign mem_re      = (state_q == ST_ISSUE);
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done        = (state_q == ST_DONE);
  assign misaligned  = misaligned_q;
  assign mem_addr    = mem_addr_q;
  assign MDR_out     = mdr_q;
  assign ls_ctrl_out = ls_ctrl_out_q;

endmodule
